// File: rtl/dff_ram_4x72_arbiter_if.sv
// Request/response and RAM-side bundle for the two-port dff_ram_4x72 arbiter.
// slave = arbiter side, master = requesters plus the RAM.
interface dff_ram_4x72_arbiter_if;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic        req_we_0, req_we_1;
    logic [1:0]  req_addr_0, req_addr_1;
    logic [71:0] req_wdata_0, req_wdata_1;
    logic        rsp_valid_0, rsp_valid_1;
    logic [71:0] rsp_rdata_0, rsp_rdata_1;
    logic        ram_en;
    logic        ram_wr;
    logic [1:0]  ram_address;
    logic [71:0] ram_wdata;
    logic [71:0] ram_rdata;

    modport slave (
        input  req_valid_0, req_valid_1, req_we_0, req_we_1,
        input  req_addr_0, req_addr_1, req_wdata_0, req_wdata_1,
        output req_ready_0, req_ready_1,
        output rsp_valid_0, rsp_valid_1, rsp_rdata_0, rsp_rdata_1,
        output ram_en, ram_wr, ram_address, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output req_valid_0, req_valid_1, req_we_0, req_we_1,
        output req_addr_0, req_addr_1, req_wdata_0, req_wdata_1,
        input  req_ready_0, req_ready_1,
        input  rsp_valid_0, rsp_valid_1, rsp_rdata_0, rsp_rdata_1,
        input  ram_en, ram_wr, ram_address, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/dff_ram_4x72_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of a 4x72 registered-read RAM.
// Define DFF_RAM_ARB_INIT_EN to zero-fill the RAM after every reset.
module dff_ram_4x72_arbiter (
    input  logic                   clk,
    input  logic                   rst,
    dff_ram_4x72_arbiter_if.slave  bus
);
    localparam int NUM_PORTS = 2;
    localparam int DW        = 72;

    logic [NUM_PORTS-1:0]         req_valid, req_we;
    logic [NUM_PORTS-1:0][1:0]    req_addr;
    logic [NUM_PORTS-1:0][DW-1:0] req_wdata;

    assign req_valid = {bus.req_valid_1, bus.req_valid_0};
    assign req_we    = {bus.req_we_1, bus.req_we_0};
    assign req_addr  = {bus.req_addr_1, bus.req_addr_0};
    assign req_wdata = {bus.req_wdata_1, bus.req_wdata_0};

    logic run;
`ifdef DFF_RAM_ARB_INIT_EN
    typedef enum logic {S_INIT, S_RUN} state_e;
    state_e     state_q;
    logic [1:0] init_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_INIT;
            init_cnt_q <= 2'd0;
        end else if (state_q == S_INIT) begin
            init_cnt_q <= init_cnt_q + 2'd1;
            if (init_cnt_q == 2'd3) state_q <= S_RUN;
        end
    end

    assign run = (state_q == S_RUN);
`else
    assign run = 1'b1;
`endif

    logic prio_q, prio_d;
    logic pend_v_q, pend_v_d;
    logic pend_port_q, pend_port_d;
    logic gnt_v, gnt_port;

    // Ready is forced low while rst is high, even though run is not yet meaningful.
    assign gnt_v    = run && !rst && (|req_valid);
    assign gnt_port = (&req_valid) ? prio_q : req_valid[1];

    assign bus.req_ready_0 = gnt_v && !gnt_port;
    assign bus.req_ready_1 = gnt_v &&  gnt_port;

    always_comb begin
        bus.ram_en      = 1'b1;
        bus.ram_wr      = 1'b1;
        bus.ram_address = 2'd0;
        bus.ram_wdata   = '0;
        if (!rst) begin
`ifdef DFF_RAM_ARB_INIT_EN
            if (state_q == S_INIT) begin
                bus.ram_en      = 1'b0;
                bus.ram_wr      = 1'b0;
                bus.ram_address = init_cnt_q;
            end
`endif
            if (gnt_v) begin
                bus.ram_en      = 1'b0;
                bus.ram_wr      = ~req_we[gnt_port];
                bus.ram_address = req_addr[gnt_port];
                bus.ram_wdata   = req_wdata[gnt_port];
            end
        end
    end

    assign prio_d      = gnt_v ? ~gnt_port : prio_q;
    assign pend_v_d    = gnt_v && !req_we[gnt_port];
    assign pend_port_d = gnt_port;

    logic [NUM_PORTS-1:0]         rsp_valid_q, rsp_valid_d;
    logic [NUM_PORTS-1:0][DW-1:0] rsp_rdata_q, rsp_rdata_d;

    // RAM read data is registered inside the RAM, so it lands one edge after accept.
    always_comb begin
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_q;
        if (pend_v_q) begin
            rsp_valid_d[pend_port_q] = 1'b1;
            rsp_rdata_d[pend_port_q] = bus.ram_rdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q      <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_port_q <= 1'b0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            prio_q      <= prio_d;
            pend_v_q    <= pend_v_d;
            pend_port_q <= pend_port_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign bus.rsp_valid_0 = rsp_valid_q[0];
    assign bus.rsp_valid_1 = rsp_valid_q[1];
    assign bus.rsp_rdata_0 = rsp_rdata_q[0];
    assign bus.rsp_rdata_1 = rsp_rdata_q[1];
endmodule

// File: tb/tb_dff_ram_4x72_arbiter.sv
// Scoreboard bench for dff_ram_4x72_arbiter: random and directed traffic on both
// ports against a behavioural RAM/arbitration model; responses checked by a monitor.
module tb_dff_ram_4x72_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dff_ram_4x72_arbiter_if bus();
    dff_ram_4x72_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef DFF_RAM_ARB_INIT_EN
    localparam int INIT_CYC = 4;
`else
    localparam int INIT_CYC = 0;
`endif

    typedef struct { bit idle; bit we; logic [1:0] addr; logic [71:0] data; } req_t;
    typedef struct { bit port; logic [71:0] data; int due; } exp_t;

    req_t rq0[$], rq1[$];
    exp_t expq[$];
    int   n_pass = 0, n_tot = 0, cyc = 0, init_left = 0;
    bit   prio_m = 1'b0;
    bit   [1:0] acc = '0;
    logic [71:0] last_rd [2];

    // Power-up contents shared by the RAM stand-in and the reference memory.
    logic [71:0] ram_mem [4] = '{72'hA5_0000_0000_0000_0011, 72'h5A_0000_0000_0000_0022,
                                 72'hC3_0000_0000_0000_0033, 72'h3C_0000_0000_0000_0044};
    logic [71:0] mem_m   [4] = '{72'hA5_0000_0000_0000_0011, 72'h5A_0000_0000_0000_0022,
                                 72'hC3_0000_0000_0000_0033, 72'h3C_0000_0000_0000_0044};

    function automatic void check(string name, logic [71:0] act, logic [71:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk)
        if (!bus.ram_en) begin
            if (!bus.ram_wr) ram_mem[bus.ram_address] <= bus.ram_wdata;
            else             bus.ram_rdata <= ram_mem[bus.ram_address];
        end

    // Reference model: arbitration rule, memory contents, expected read responses.
    always @(negedge clk) begin
        bit [1:0] v;
        bit g;
        bit we;
        logic [1:0] a;
        logic [71:0] d;
        acc = '0;
        if (rst) begin
            prio_m    = 1'b0;
            init_left = INIT_CYC;
            expq.delete();
            if (INIT_CYC > 0) mem_m = '{default: '0};
            check("rst_ready", {70'd0, bus.req_ready_1, bus.req_ready_0}, 72'd0);
            check("rst_ram_ctl", {70'd0, bus.ram_en, bus.ram_wr}, 72'd3);
            check("rst_ram_addr", {70'd0, bus.ram_address}, 72'd0);
            check("rst_ram_wdata", bus.ram_wdata, 72'd0);
        end else if (init_left > 0) begin
            check("init_ready", {70'd0, bus.req_ready_1, bus.req_ready_0}, 72'd0);
            check("init_ram_ctl", {70'd0, bus.ram_en, bus.ram_wr}, 72'd0);
            check("init_ram_addr", {70'd0, bus.ram_address}, 72'(INIT_CYC - init_left));
            check("init_ram_wdata", bus.ram_wdata, 72'd0);
            init_left--;
        end else begin
            v = {bus.req_valid_1, bus.req_valid_0};
            g = (v == 2'b11) ? prio_m : v[1];
            we = g ? bus.req_we_1 : bus.req_we_0;
            a  = g ? bus.req_addr_1 : bus.req_addr_0;
            d  = g ? bus.req_wdata_1 : bus.req_wdata_0;
            check("ready", {70'd0, bus.req_ready_1, bus.req_ready_0},
                  (v == 2'b00) ? 72'd0 : (g ? 72'd2 : 72'd1));
            if (v == 2'b00) begin
                check("idle_ram_ctl", {70'd0, bus.ram_en, bus.ram_wr}, 72'd3);
                check("idle_ram_bus", {bus.ram_wdata[69:0], bus.ram_address}, 72'd0);
            end else begin
                check("gnt_ram_ctl", {70'd0, bus.ram_en, bus.ram_wr}, {70'd0, 1'b0, ~we});
                check("gnt_ram_addr", {70'd0, bus.ram_address}, {70'd0, a});
                if (we) check("gnt_ram_wdata", bus.ram_wdata, d);
                acc[g] = 1'b1;
                if (we) mem_m[a] = d;
                else    expq.push_back('{port: g, data: mem_m[a], due: cyc + 2});
                prio_m = ~g;
            end
        end
    end

    // Monitor: pops the scoreboard whenever a response pulse appears.
    always @(negedge clk) begin
        exp_t e;
        bit p;
        if (rst) begin
            check("rst_rsp_valid", {70'd0, bus.rsp_valid_1, bus.rsp_valid_0}, 72'd0);
            check("rst_rsp_rdata0", bus.rsp_rdata_0, 72'd0);
            check("rst_rsp_rdata1", bus.rsp_rdata_1, 72'd0);
            last_rd[0] = '0;
            last_rd[1] = '0;
        end else begin
            if (bus.rsp_valid_0 || bus.rsp_valid_1) begin
                check("rsp_one_port", {71'd0, bus.rsp_valid_0 & bus.rsp_valid_1}, 72'd0);
                if (expq.size() == 0) begin
                    check("rsp_spurious", {70'd0, bus.rsp_valid_1, bus.rsp_valid_0}, 72'd0);
                end else begin
                    e = expq.pop_front();
                    p = bus.rsp_valid_1;
                    check("rsp_port", {71'd0, p}, {71'd0, e.port});
                    check("rsp_rdata", p ? bus.rsp_rdata_1 : bus.rsp_rdata_0, e.data);
                    check("rsp_latency", 72'(cyc), 72'(e.due));
                    last_rd[p] = e.data;
                end
            end else if (expq.size() > 0 && expq[0].due < cyc) begin
                e = expq.pop_front();
                check("rsp_missing", {70'd0, bus.rsp_valid_1, bus.rsp_valid_0},
                      e.port ? 72'd2 : 72'd1);
            end
            if (!bus.rsp_valid_0) check("rsp_hold0", bus.rsp_rdata_0, last_rd[0]);
            if (!bus.rsp_valid_1) check("rsp_hold1", bus.rsp_rdata_1, last_rd[1]);
        end
    end

    // Driver: presents each port's queue head and holds it until accepted.
    initial begin
        bit pres0, pres1;
        pres0 = 1'b0;
        pres1 = 1'b0;
        bus.req_valid_0 = 1'b0; bus.req_we_0 = 1'b0; bus.req_addr_0 = '0; bus.req_wdata_0 = '0;
        bus.req_valid_1 = 1'b0; bus.req_we_1 = 1'b0; bus.req_addr_1 = '0; bus.req_wdata_1 = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pres0 && (acc[0] || rq0[0].idle)) begin void'(rq0.pop_front()); pres0 = 1'b0; end
            if (pres1 && (acc[1] || rq1[0].idle)) begin void'(rq1.pop_front()); pres1 = 1'b0; end
            if (rq0.size() > 0) begin
                pres0 = 1'b1;
                bus.req_valid_0 = !rq0[0].idle; bus.req_we_0 = rq0[0].we;
                bus.req_addr_0  = rq0[0].addr;  bus.req_wdata_0 = rq0[0].data;
            end else bus.req_valid_0 = 1'b0;
            if (rq1.size() > 0) begin
                pres1 = 1'b1;
                bus.req_valid_1 = !rq1[0].idle; bus.req_we_1 = rq1[0].we;
                bus.req_addr_1  = rq1[0].addr;  bus.req_wdata_1 = rq1[0].data;
            end else bus.req_valid_1 = 1'b0;
        end
    end

    task automatic push(input bit k, input bit idle, input bit we, input logic [1:0] a,
                        input logic [71:0] d);
        if (k) rq1.push_back('{idle: idle, we: we, addr: a, data: d});
        else   rq0.push_back('{idle: idle, we: we, addr: a, data: d});
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((rq0.size() > 0 || rq1.size() > 0 || expq.size() > 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        check("drain_in_budget", {71'd0, n < budget}, 72'd1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        logic [95:0] rnd;
        int n;
        // Reads queued during reset: ready must stay low until RUN.
        for (int i = 0; i < 4; i++) push(1'b0, 1'b0, 1'b0, 2'(i), '0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        drain(200);

        push(1'b1, 1'b0, 1'b1, 2'd2, 72'hAB_CDEF_0123_4567_89AB);
        push(1'b1, 1'b0, 1'b0, 2'd2, '0);
        drain(100);

        for (int i = 0; i < 3; i++) begin
            push(1'b0, 1'b0, 1'b0, 2'(i), '0);
            push(1'b1, 1'b0, 1'b0, 2'(i + 1), '0);
        end
        drain(100);

        push(1'b0, 1'b0, 1'b1, 2'd3, 72'h1);
        push(1'b1, 1'b1, 1'b0, 2'd0, '0);
        push(1'b1, 1'b0, 1'b0, 2'd3, '0);
        drain(100);

        // Reset lands between the accept edge and the data-return edge.
        push(1'b0, 1'b0, 1'b0, 2'd3, '0);
        n = 0;
        do begin @(negedge clk); #1; n++; end while (!acc[0] && n < 50);
        check("midrst_accept", {71'd0, acc[0]}, 72'd1);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        drain(100);

        repeat (10) @(posedge clk);
        for (int i = 0; i < 4; i++) push(1'b1, 1'b0, 1'b0, 2'(i), '0);
        drain(100);

        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < 2; k++) begin
                rnd = {$urandom, $urandom, $urandom};
                push(k[0], ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                     2'($urandom_range(0, 3)), rnd[71:0]);
            end
        end
        drain(5000);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_tot);
        $fatal(1);
    end
endmodule
